blink_multi: RTL and testbench

- Multi-channel LED blink generator, parametrised successor to the single-channel 26-bit blinker.
- One free-running prescaler produces a shared tick. NCH independent channels each run OFF / ON / BLINK / BURST modes with a programmable half-period and burst count.
- Configured through a single-cycle write port from the board-control logic. Drives front-panel LEDs.

---
 rtl/blink_multi.sv | 151 +++++++++++++++
 tb/tb_blink_multi.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_multi.sv
// Multi-channel LED blinker: shared prescaler tick drives NCH channels in OFF/ON/BLINK/BURST modes.
// Optional phase-sync input is enabled by defining BLINK_SYNC_EN.
module blink_multi #(
  parameter int CBITS = 26,
  parameter int NCH   = 4,
  parameter int HBITS = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                              cfg_mode,
  input  logic [HBITS-1:0]                        cfg_half,
  input  logic [3:0]                              cfg_burst,
`ifdef BLINK_SYNC_EN
  input  logic                                    sync,
`endif
  output logic [NCH-1:0]                          led,
  output logic                                    flg
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW:0] NCH_L = (CW+1)'(NCH);

  typedef enum logic [1:0] {
    M_OFF   = 2'b00,
    M_ON    = 2'b01,
    M_BLINK = 2'b10,
    M_BURST = 2'b11
  } mode_t;

  logic [CBITS-1:0] pre;
  logic             tick;
  logic             sync_i;
  logic             wr_ok;

`ifdef BLINK_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  assign tick  = (pre == '0);
  assign wr_ok = cfg_we && ({1'b0, cfg_ch} < NCH_L);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre <= '0;
      flg <= 1'b0;
    end else if (sync_i) begin
      pre <= CBITS'(1);
      flg <= 1'b1;
    end else begin
      pre <= pre + CBITS'(1);
      flg <= tick;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mode_t            mode;
    logic [HBITS-1:0] half;
    logic [HBITS-1:0] ph;
    logic [3:0]       burst;
    logic [3:0]       bcnt;
    logic [3:0]       blim;
    logic             gap;
    logic [HBITS+1:0] gcnt;
    logic             lvl;
    logic             hit;

    assign hit  = wr_ok && (cfg_ch == CW'(i));
    assign blim = (burst == 4'd0) ? 4'd1 : burst;

    always_ff @(posedge clk) begin
      if (!rst) begin
        mode  <= M_OFF;
        half  <= '0;
        burst <= '0;
        ph    <= '0;
        bcnt  <= '0;
        gap   <= 1'b0;
        gcnt  <= '0;
        lvl   <= 1'b0;
      end else if (sync_i) begin
        ph   <= '0;
        bcnt <= '0;
        gap  <= 1'b0;
        gcnt <= '0;
        lvl  <= (mode == M_ON);
      end else if (hit) begin
        mode  <= mode_t'(cfg_mode);
        half  <= cfg_half;
        burst <= cfg_burst;
        ph    <= '0;
        bcnt  <= '0;
        gap   <= 1'b0;
        gcnt  <= '0;
        lvl   <= (cfg_mode == M_ON);
      end else if (tick) begin
        case (mode)
          M_BLINK: begin
            if (ph == half) begin
              ph  <= '0;
              lvl <= ~lvl;
            end else begin
              ph <= ph + HBITS'(1);
            end
          end
          M_BURST: begin
            // Gap lasts 4*(half+1) ticks; {half,2'b11} is that count minus one.
            if (gap) begin
              if (gcnt == {half, 2'b11}) begin
                gap  <= 1'b0;
                gcnt <= '0;
                ph   <= '0;
              end else begin
                gcnt <= gcnt + (HBITS+2)'(1);
              end
            end else if (ph == half) begin
              ph  <= '0;
              lvl <= ~lvl;
              if (lvl) begin
                if (bcnt + 4'd1 == blim) begin
                  gap  <= 1'b1;
                  bcnt <= '0;
                end else begin
                  bcnt <= bcnt + 4'd1;
                end
              end
            end else begin
              ph <= ph + HBITS'(1);
            end
          end
          M_ON: begin
            lvl  <= 1'b1;
            ph   <= '0;
            bcnt <= '0;
          end
          default: begin
            lvl  <= 1'b0;
            ph   <= '0;
            bcnt <= '0;
          end
        endcase
      end
    end

    assign led[i] = lvl;
  end

endmodule

// File: tb/tb_blink_multi.sv
// Self-checking bench for blink_multi: per-cycle comparison against a tick-count model plus literal pins.
// NCH=5 so the 3-bit channel index can express out-of-range values such as 5 and 7.
module tb_blink_multi;

  localparam int CBITS = 4;
  localparam int NCH   = 5;
  localparam int HBITS = 8;
  localparam int PER   = 1 << CBITS;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [1:0]     cfg_mode;
  logic [HBITS-1:0] cfg_half;
  logic [3:0]     cfg_burst;
`ifdef BLINK_SYNC_EN
  logic           sync;
`endif
  logic [NCH-1:0] led;
  logic           flg;

  int tests = 0;
  int fails = 0;

  blink_multi #(.CBITS(CBITS), .NCH(NCH), .HBITS(HBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_half (cfg_half),
    .cfg_burst(cfg_burst),
`ifdef BLINK_SYNC_EN
    .sync     (sync),
`endif
    .led      (led),
    .flg      (flg)
  );

  always #5 clk = ~clk;

  // Model: prescaler phase plus, per channel, the number of ticks since its last write/sync.
  bit   armed = 1'b0;
  int   pcnt  = 0;
  logic flg_m = 1'b0;
  int   mode_m[NCH];
  int   half_m[NCH];
  int   burst_m[NCH];
  int   k_m[NCH];

  always @(posedge clk) begin
    bit tk;
    bit sy;
    sy = 1'b0;
`ifdef BLINK_SYNC_EN
    sy = (sync === 1'b1);
`endif
    if (rst === 1'b0) begin
      armed = 1'b1;
      pcnt  = 0;
      flg_m = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        mode_m[i] = 0; half_m[i] = 0; burst_m[i] = 0; k_m[i] = 0;
      end
    end else if (sy) begin
      pcnt  = 1;
      flg_m = 1'b1;
      for (int i = 0; i < NCH; i++) k_m[i] = 0;
    end else begin
      tk    = (pcnt == 0);
      flg_m = tk;
      pcnt  = (pcnt + 1) % PER;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we === 1'b1 && int'(cfg_ch) == i) begin
          mode_m[i]  = int'(cfg_mode);
          half_m[i]  = int'(cfg_half);
          burst_m[i] = int'(cfg_burst);
          k_m[i]     = 0;
        end else if (tk) begin
          k_m[i] = k_m[i] + 1;
        end
      end
    end
  end

  function automatic logic exp_ch(int i);
    int h1, b, m, q;
    h1 = half_m[i] + 1;
    case (mode_m[i])
      0: return 1'b0;
      1: return 1'b1;
      2: return ((k_m[i] / h1) % 2) == 1;
      default: begin
        b = (burst_m[i] == 0) ? 1 : burst_m[i];
        m = k_m[i] % ((2 * b + 4) * h1);
        q = m / h1;
        return (q < 2 * b) && ((q % 2) == 1);
      end
    endcase
  endfunction

  function automatic logic [NCH-1:0] exp_led();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = exp_ch(i);
    return v;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      tests++;
      if (led !== exp_led()) begin
        fails++;
        $display("FAIL model_led t=%0t: got %b expected %b", $time, led, exp_led());
      end
      tests++;
      if (flg !== flg_m) begin
        fails++;
        $display("FAIL model_flg t=%0t: got %b expected %b", $time, flg, flg_m);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int mode, input int half, input int burst);
    cfg_we    = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_mode  = 2'(mode);
    cfg_half  = HBITS'(half);
    cfg_burst = 4'(burst);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic wait_flg();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (flg !== 1'b1 && n < 3 * PER);
    if (flg !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_flg t=%0t: got flg=%b after %0d cycles, required 1", $time, flg, n);
    end
  endtask

  initial begin
    int pat3[11];
    int pat1[7];
    pat3 = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1};
    pat1 = '{1, 0, 0, 0, 0, 0, 1};
    rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_burst = '0;
`ifdef BLINK_SYNC_EN
    sync = 1'b0;
`endif
    cyc(3);
    pin("reset_led", 32'(led), 32'h0);
    pin("reset_flg", 32'(flg), 32'h0);
    rst = 1'b1;
    cyc(1);
    pin("first_flg", 32'(flg), 32'h1);
    cyc(15);
    pin("flg_gap", 32'(flg), 32'h0);
    cyc(1);
    pin("flg_period", 32'(flg), 32'h1);

    // ch0 BLINK half=2: toggles every 3 ticks
    wr(0, 2, 2, 0);
    repeat (3) wait_flg();
    pin("blink_rise", 32'(led), 32'h01);
    repeat (3) wait_flg();
    pin("blink_fall", 32'(led), 32'h00);

    // ch1 BURST half=0, burst=3 then burst=0
    wr(1, 3, 0, 3);
    for (int j = 0; j < 11; j++) begin
      wait_flg();
      pin($sformatf("burst3_tick%0d", j + 1), 32'(led[1]), 32'(pat3[j]));
    end
    wr(1, 3, 0, 0);
    for (int j = 0; j < 7; j++) begin
      wait_flg();
      pin($sformatf("burst0_tick%0d", j + 1), 32'(led[1]), 32'(pat1[j]));
    end

    // ch2 ON, then out-of-range writes
    wr(2, 1, 0, 0);
    pin("on_immediate", 32'(led[2]), 32'h1);
    wr(7, 0, 5, 5);
    wr(5, 3, 1, 1);
    pin("bad_ch_keep_on", 32'(led[2]), 32'h1);

    // ch3 BLINK half=1, then a ch0 write landing exactly on a tick edge
    wr(3, 2, 1, 0);
    wait_flg();
    cyc(PER - 1);
    wr(0, 2, 0, 0);
    pin("tick_write_flg", 32'(flg), 32'h1);
    pin("tick_write_ch0", 32'(led[0]), 32'h0);
    pin("tick_write_ch3", 32'(led[3]), 32'h1);
    wait_flg();
    pin("after_write_ch0", 32'(led[0]), 32'h1);
    pin("after_write_ch3", 32'(led[3]), 32'h1);

    // reset in the middle of ch1's burst
    rst = 1'b0;
    cyc(1);
    pin("midrst_led", 32'(led), 32'h0);
    pin("midrst_flg", 32'(flg), 32'h0);
    cyc(2);
    rst = 1'b1;
    repeat (2) wait_flg();
    pin("post_rst_off", 32'(led), 32'h0);

`ifdef BLINK_SYNC_EN
    wr(0, 2, 1, 0);
    wait_flg();
    wr(3, 2, 1, 0);
    wait_flg();
    pin("presync_phase", 32'(led), 32'h01);
    cyc(5);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    pin("sync_flg", 32'(flg), 32'h1);
    pin("sync_led", 32'(led), 32'h0);
    wait_flg();
    pin("sync_tick1", 32'(led), 32'h0);
    wait_flg();
    pin("sync_tick2", 32'(led), 32'h09);
`endif

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
